// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order buffer of fetched {pc, instr} pairs; head is read combinationally
// so decode sees the oldest word in the same cycle it is buffered.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output fetch_entry_t  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_i && full && !pop_i));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, credit-limited memory requests,
// response buffering and branch redirect with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          blank_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          redirect;
  logic          req_hs;
  logic [31:0]   target_pc;
  logic [CW:0]   credit_used;
  logic          unused_target_lsbs;

  assign redirect           = PCSrc && (state_q != BOOT);
  assign target_pc          = {PCTarget[31:2], 2'b00};
  assign unused_target_lsbs = ^PCTarget[1:0];

  assign fifo_pop = instr_valid && instr_ready;
  // A head leaving this cycle frees its slot, which sustains one word per cycle at DEPTH=2.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};

  assign imem_req_valid = (state_q == RUN) && !blank_q && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign fifo_push  = (state_q == RUN) && imem_rsp_valid && (drop_q == '0) && !redirect;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (req_hs) begin
          outstanding_d = outstanding_d + 1'b1;
          fetch_pc_d    = fetch_pc_q + INSTR_BYTES;
        end
        if (imem_rsp_valid) begin
          outstanding_d = outstanding_d - 1'b1;
          rsp_pc_d      = rsp_pc_q + INSTR_BYTES;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          outstanding_d = outstanding_q - 1'b1;
          drop_d        = drop_q - 1'b1;
          if (drop_q == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // Everything still in flight after this edge belongs to the old path.
    if (redirect) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      blank_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      blank_q       <= redirect;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (fifo_push),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .clear_i    (redirect),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1- or 2-cycle in-order memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;

  logic        s1_v, s2_v;
  logic [31:0] s1_d, s2_d;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_ins_log[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h13A5_0000;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= imem_req_valid && imem_req_ready;
      s1_d <= mem_word(imem_req_addr);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end
  assign imem_rsp_valid = (lat == 1) ? s1_v : s2_v;
  assign imem_rsp_data  = (lat == 1) ? s1_d : s2_d;

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
      if (instr_valid && instr_ready) begin
        pop_pc_log.push_back(instr_pc);
        pop_ins_log.push_back(instr);
        $display("pop pc=%h instr=%h", instr_pc, instr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the BOOT cycle right after release.
  task automatic do_reset(input int latency);
    cyc();
    rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    lat = latency;
    cyc();
    cyc();
    rst_n = 1'b1;
    req_log.delete(); pop_pc_log.delete(); pop_ins_log.delete();
  endtask

  task automatic test_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
  endtask

  task automatic test_latency();
    do_reset(1);
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_req_valid: got %b expected 0", imem_req_valid); end
    cyc(); #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid_c1: got %b expected 0", instr_valid); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid_c2: got %b expected 0", instr_valid); end
    cyc(); #1;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== mem_word(32'(4 * k))) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", k, instr_valid, instr_pc, instr, 32'(4 * k), mem_word(32'(4 * k)));
      end
      cyc(); #1;
    end
    for (int i = 0; i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL req_addr_%0d: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    instr_ready = 1'b0;
    repeat (10) cyc();
    #1;
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got valid=%b pc=%h expected 1/00000000", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume_req: got valid=%b addr=%h expected 1/00000008", imem_req_valid, imem_req_addr); end
    repeat (8) cyc();
    n_checks++; if (pop_pc_log.size() < 5) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected >=5", pop_pc_log.size()); end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      n_checks++;
      if (pop_pc_log[i] !== 32'(4 * i) || pop_ins_log[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL bp_order_%0d: got pc=%h instr=%h expected %h/%h", i, pop_pc_log[i], pop_ins_log[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_ready_toggle();
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      cyc();
      imem_req_ready = ~imem_req_ready;
    end
    imem_req_ready = 1'b1;
    n_checks++; if (pop_pc_log.size() < 8) begin n_fail++; $display("FAIL tog_pop_count: got %0d expected >=8", pop_pc_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL tog_req_%0d: got %h expected %h", i, req_log[i], 32'(4 * i)); end
    end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      n_checks++;
      if (pop_pc_log[i] !== 32'(4 * i) || pop_ins_log[i] !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL tog_pop_%0d: got pc=%h instr=%h expected %h/%h", i, pop_pc_log[i], pop_ins_log[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_redirect_drain();
    int waited;
    do_reset(2);
    cyc();
    cyc();
    PCSrc = 1'b1; PCTarget = 32'h100;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rd_hs_req_valid: got %b expected 1", imem_req_valid); end
    cyc();
    PCSrc = 1'b0;
    pop_pc_log.delete(); pop_ins_log.delete();
    #1;
    n_checks++; if (dut.state_q !== DRAIN) begin n_fail++; $display("FAIL rd_state_c3: got %0d expected %0d", dut.state_q, DRAIN); end
    n_checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_quiet_c3: got req=%b ivalid=%b expected 0/0", imem_req_valid, instr_valid); end
    cyc(); #1;
    n_checks++; if (dut.state_q !== DRAIN) begin n_fail++; $display("FAIL rd_state_c4: got %0d expected %0d", dut.state_q, DRAIN); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_ivalid_c4: got %b expected 0", instr_valid); end
    cyc(); #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rd_target_req: got valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_ivalid_c5: got %b expected 0", instr_valid); end
    waited = 0;
    while (pop_pc_log.size() == 0 && waited < 12) begin cyc(); waited++; end
    n_checks++;
    if (pop_pc_log.size() == 0) begin
      n_fail++; $display("FAIL rd_first_pop: got timeout expected pc 00000100");
    end else if (pop_pc_log[0] !== 32'h100 || pop_ins_log[0] !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL rd_first_pop: got pc=%h instr=%h expected 00000100/%h", pop_pc_log[0], pop_ins_log[0], mem_word(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    do_reset(1);
    repeat (4) cyc();
    PCSrc = 1'b1; PCTarget = 32'h180;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got req=%b ivalid=%b expected 1/1", imem_req_valid, instr_valid); end
    cyc();
    pop_pc_log.delete(); pop_ins_log.delete();
    PCTarget = 32'h200;
    #1;
    n_checks++; if (dut.state_q !== DRAIN) begin n_fail++; $display("FAIL b2b_state_drain: got %0d expected %0d", dut.state_q, DRAIN); end
    n_checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_quiet: got req=%b ivalid=%b expected 0/0", imem_req_valid, instr_valid); end
    cyc();
    PCSrc = 1'b0;
    #1;
    n_checks++; if (dut.state_q !== RUN) begin n_fail++; $display("FAIL b2b_state_run: got %0d expected %0d", dut.state_q, RUN); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_blank: got %b expected 0", imem_req_valid); end
    cyc(); #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_target_req: got valid=%b addr=%h expected 1/00000200", imem_req_valid, imem_req_addr); end
    waited = 0;
    while (pop_pc_log.size() < 3 && waited < 15) begin cyc(); waited++; end
    n_checks++; if (pop_pc_log.size() < 3) begin n_fail++; $display("FAIL b2b_pop_count: got %0d expected >=3", pop_pc_log.size()); end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      n_checks++;
      if (pop_pc_log[i] !== 32'h200 + 32'(4 * i) || pop_ins_log[i] !== mem_word(32'h200 + 32'(4 * i))) begin
        n_fail++; $display("FAIL b2b_pop_%0d: got pc=%h instr=%h expected %h", i, pop_pc_log[i], pop_ins_log[i], 32'h200 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_boot_pcsrc();
    do_reset(1);
    PCSrc = 1'b1; PCTarget = 32'h300;
    cyc();
    PCSrc = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL boot_pcsrc: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_reset_midstream();
    int waited;
    do_reset(1);
    instr_ready = 1'b0;
    repeat (6) cyc();
    #1;
    n_checks++; if (instr_valid !== 1'b1 || dut.fifo_count !== 2'd2) begin n_fail++; $display("FAIL mid_full: got valid=%b count=%0d expected 1/2", instr_valid, dut.fifo_count); end
    rst_n = 1'b0;
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outs: got ivalid=%b req=%b expected 0/0", instr_valid, imem_req_valid); end
    rst_n = 1'b1; instr_ready = 1'b1;
    req_log.delete(); pop_pc_log.delete(); pop_ins_log.delete();
    cyc(); #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL mid_refetch: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr); end
    cyc();
    PCSrc = 1'b1; PCTarget = 32'h203;
    cyc();
    PCSrc = 1'b0;
    req_log.delete(); pop_pc_log.delete(); pop_ins_log.delete();
    waited = 0;
    while (pop_pc_log.size() == 0 && waited < 15) begin cyc(); waited++; end
    n_checks++;
    if (req_log.size() == 0) begin
      n_fail++; $display("FAIL mid_target_req: got no request expected 00000200");
    end else if (req_log[0] !== 32'h200) begin
      n_fail++; $display("FAIL mid_target_req: got %h expected 00000200", req_log[0]);
    end
    n_checks++;
    if (pop_pc_log.size() == 0) begin
      n_fail++; $display("FAIL mid_target_pop: got timeout expected 00000200");
    end else if (pop_pc_log[0] !== 32'h200) begin
      n_fail++; $display("FAIL mid_target_pop: got %h expected 00000200", pop_pc_log[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    test_reset();
    test_latency();
    test_backpressure();
    test_ready_toggle();
    test_redirect_drain();
    test_back_to_back();
    test_boot_pcsrc();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
